msm_counter_bank: RTL and testbench

//  Bank of C_CHANNELS independent up/down counters with per-channel load and step size.

---
 rtl/msm_counter_bank_if.sv | 33 +++
 rtl/msm_counter_bank.sv | 97 +++++++++
 tb/tb_msm_counter_bank.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/msm_counter_bank_if.sv
// Control and status bundle for msm_counter_bank.
// The counter bank is the slave; whoever drives the requests is the master.
interface msm_counter_bank_if #(
  parameter int C_CHANNELS   = 4,
  parameter int C_WIDTH      = 16,
  parameter int C_STEP_WIDTH = 4
);
  logic                               clken;
  logic [C_CHANNELS-1:0]              load;
  logic [C_CHANNELS-1:0]              incr;
  logic [C_CHANNELS-1:0]              decr;
  logic [C_CHANNELS*C_STEP_WIDTH-1:0] step;
  logic [C_CHANNELS*C_WIDTH-1:0]      load_value;
  logic                               err_clr;
  logic [C_CHANNELS*C_WIDTH-1:0]      count;
  logic [C_CHANNELS-1:0]              is_zero;
  logic [C_CHANNELS-1:0]              is_max;
  logic [C_CHANNELS-1:0]              ovf;
  logic [C_CHANNELS-1:0]              unf;
  logic [C_CHANNELS-1:0]              err_sticky;
  logic                               all_zero;
  logic                               any_max;

  modport master (
    output clken, load, incr, decr, step, load_value, err_clr,
    input  count, is_zero, is_max, ovf, unf, err_sticky, all_zero, any_max
  );

  modport slave (
    input  clken, load, incr, decr, step, load_value, err_clr,
    output count, is_zero, is_max, ovf, unf, err_sticky, all_zero, any_max
  );
endinterface

// File: rtl/msm_counter_bank.sv
// Bank of independent up/down counters with per-channel load and step size,
// saturating or wrapping arithmetic, and registered zero/max/error status.
module msm_counter_bank #(
  parameter int                  C_CHANNELS   = 4,
  parameter int                  C_WIDTH      = 16,
  parameter int                  C_STEP_WIDTH = 4,
  parameter logic [C_WIDTH-1:0]  C_INIT       = '0,
  parameter bit                  C_SATURATE   = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  msm_counter_bank_if.slave  bus
);

  localparam logic [C_WIDTH-1:0] MAX_VAL   = '1;
  localparam bit                 INIT_ZERO = (C_INIT == '0);
  localparam bit                 INIT_MAX  = (C_INIT == MAX_VAL);

  logic [C_CHANNELS*C_WIDTH-1:0] cnt_q, cnt_d;
  logic [C_CHANNELS-1:0]         zero_q, zero_d;
  logic [C_CHANNELS-1:0]         max_q, max_d;
  logic [C_CHANNELS-1:0]         ovf_q, ovf_d;
  logic [C_CHANNELS-1:0]         unf_q, unf_d;
  logic [C_CHANNELS-1:0]         err_q, err_d;
  logic                          all_zero_q, any_max_q;

  for (genvar i = 0; i < C_CHANNELS; i++) begin : g_ch
    logic [C_WIDTH-1:0]      cur;
    logic [C_WIDTH-1:0]      nxt;
    logic [C_STEP_WIDTH-1:0] stp;
    logic [C_WIDTH:0]        sum;
    logic [C_WIDTH:0]        diff;
    logic                    o, u;

    assign cur  = cnt_q[i*C_WIDTH +: C_WIDTH];
    assign stp  = bus.step[i*C_STEP_WIDTH +: C_STEP_WIDTH];
    // One extra bit: carry out of sum means overflow, borrow out of diff means underflow.
    assign sum  = {1'b0, cur} + {{(C_WIDTH+1-C_STEP_WIDTH){1'b0}}, stp};
    assign diff = {1'b0, cur} - {{(C_WIDTH+1-C_STEP_WIDTH){1'b0}}, stp};

    always_comb begin
      nxt = cur;
      o   = 1'b0;
      u   = 1'b0;
      if (bus.load[i]) begin
        nxt = bus.load_value[i*C_WIDTH +: C_WIDTH];
      end else if (bus.incr[i] && !bus.decr[i]) begin
        o   = sum[C_WIDTH];
        nxt = (o && C_SATURATE) ? MAX_VAL : sum[C_WIDTH-1:0];
      end else if (bus.decr[i] && !bus.incr[i]) begin
        u   = diff[C_WIDTH];
        nxt = (u && C_SATURATE) ? '0 : diff[C_WIDTH-1:0];
      end
    end

    assign cnt_d[i*C_WIDTH +: C_WIDTH] = nxt;
    assign ovf_d[i]  = o;
    assign unf_d[i]  = u;
    assign zero_d[i] = (nxt == '0);
    assign max_d[i]  = (nxt == MAX_VAL);
  end

  // A new event in the same cycle as err_clr keeps the sticky bit set.
  assign err_d = (err_q & ~{C_CHANNELS{bus.err_clr}}) | ovf_d | unf_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= {C_CHANNELS{C_INIT}};
      zero_q     <= {C_CHANNELS{INIT_ZERO}};
      max_q      <= {C_CHANNELS{INIT_MAX}};
      ovf_q      <= '0;
      unf_q      <= '0;
      err_q      <= '0;
      all_zero_q <= INIT_ZERO;
      any_max_q  <= INIT_MAX;
    end else if (bus.clken) begin
      cnt_q      <= cnt_d;
      zero_q     <= zero_d;
      max_q      <= max_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      err_q      <= err_d;
      all_zero_q <= &zero_d;
      any_max_q  <= |max_d;
    end
  end

  assign bus.count      = cnt_q;
  assign bus.is_zero    = zero_q;
  assign bus.is_max     = max_q;
  assign bus.ovf        = ovf_q;
  assign bus.unf        = unf_q;
  assign bus.err_sticky = err_q;
  assign bus.all_zero   = all_zero_q;
  assign bus.any_max    = any_max_q;

endmodule

// File: tb/tb_msm_counter_bank.sv
// Scoreboard bench: a saturating and a wrapping counter bank share one stimulus
// stream; an integer model predicts each cycle and a monitor compares.
module tb_msm_counter_bank;

  localparam int CH = 4;
  localparam int W  = 16;
  localparam int SW = 4;
  localparam int MAXV = 65535;

  typedef struct {
    logic [63:0] count;
    logic [3:0]  zero;
    logic [3:0]  mx;
    logic [3:0]  ovf;
    logic [3:0]  unf;
    logic [3:0]  err;
    logic        all_zero;
    logic        any_max;
  } snap_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int compared = 0;
  int mismatched = 0;

  snap_t sat_q[$];
  snap_t wrap_q[$];

  int unsigned m_cnt [2][CH];
  logic [3:0]  m_ovf [2];
  logic [3:0]  m_unf [2];
  logic [3:0]  m_err [2];

  msm_counter_bank_if #(.C_CHANNELS(CH), .C_WIDTH(W), .C_STEP_WIDTH(SW)) sat_bus ();
  msm_counter_bank_if #(.C_CHANNELS(CH), .C_WIDTH(W), .C_STEP_WIDTH(SW)) wrap_bus ();

  msm_counter_bank #(.C_CHANNELS(CH), .C_WIDTH(W), .C_STEP_WIDTH(SW),
                     .C_INIT(16'h0000), .C_SATURATE(1'b1))
    dut_sat (.clk(clk), .rst_n(rst_n), .bus(sat_bus.slave));

  msm_counter_bank #(.C_CHANNELS(CH), .C_WIDTH(W), .C_STEP_WIDTH(SW),
                     .C_INIT(16'h0000), .C_SATURATE(1'b0))
    dut_wrap (.clk(clk), .rst_n(rst_n), .bus(wrap_bus.slave));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic compareSnap(input string tag, input snap_t a, input snap_t e);
    checkOutput({tag, ".count"},      a.count,           e.count);
    checkOutput({tag, ".is_zero"},    64'(a.zero),       64'(e.zero));
    checkOutput({tag, ".is_max"},     64'(a.mx),         64'(e.mx));
    checkOutput({tag, ".ovf"},        64'(a.ovf),        64'(e.ovf));
    checkOutput({tag, ".unf"},        64'(a.unf),        64'(e.unf));
    checkOutput({tag, ".err_sticky"}, 64'(a.err),        64'(e.err));
    checkOutput({tag, ".all_zero"},   64'(a.all_zero),   64'(e.all_zero));
    checkOutput({tag, ".any_max"},    64'(a.any_max),    64'(e.any_max));
  endtask

  function automatic snap_t readSat();
    snap_t r;
    r.count = sat_bus.count;   r.zero = sat_bus.is_zero;   r.mx = sat_bus.is_max;
    r.ovf = sat_bus.ovf;       r.unf = sat_bus.unf;        r.err = sat_bus.err_sticky;
    r.all_zero = sat_bus.all_zero;  r.any_max = sat_bus.any_max;
    return r;
  endfunction

  function automatic snap_t readWrap();
    snap_t r;
    r.count = wrap_bus.count;  r.zero = wrap_bus.is_zero;  r.mx = wrap_bus.is_max;
    r.ovf = wrap_bus.ovf;      r.unf = wrap_bus.unf;       r.err = wrap_bus.err_sticky;
    r.all_zero = wrap_bus.all_zero; r.any_max = wrap_bus.any_max;
    return r;
  endfunction

  function automatic snap_t modelSnap(input int d);
    snap_t s;
    s.count = '0;
    for (int c = 0; c < CH; c++) begin
      s.count[c*W +: W] = 16'(m_cnt[d][c]);
      s.zero[c] = (m_cnt[d][c] == 0);
      s.mx[c]   = (m_cnt[d][c] == MAXV);
    end
    s.ovf = m_ovf[d];
    s.unf = m_unf[d];
    s.err = m_err[d];
    s.all_zero = (s.zero == 4'hF);
    s.any_max  = (s.mx != 4'h0);
    return s;
  endfunction

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < CH; c++) m_cnt[d][c] = 0;
      m_ovf[d] = '0;
      m_unf[d] = '0;
      m_err[d] = '0;
    end
  endtask

  // Plain integer arithmetic: out-of-range results are clamped or folded back by 2^16.
  task automatic modelStep(input int d, input bit sat, input bit ce, input logic [3:0] ld,
                           input logic [3:0] inc, input logic [3:0] dec,
                           input logic [15:0] stp, input logic [63:0] lv, input bit ec);
    int s;
    int st;
    if (!ce) return;
    for (int c = 0; c < CH; c++) begin
      st = int'(stp[c*SW +: SW]);
      m_ovf[d][c] = 1'b0;
      m_unf[d][c] = 1'b0;
      if (ld[c]) begin
        m_cnt[d][c] = int'(lv[c*W +: W]);
      end else if (inc[c] && !dec[c]) begin
        s = int'(m_cnt[d][c]) + st;
        if (s > MAXV) begin
          m_ovf[d][c] = 1'b1;
          s = sat ? MAXV : s - (MAXV + 1);
        end
        m_cnt[d][c] = s;
      end else if (dec[c] && !inc[c]) begin
        s = int'(m_cnt[d][c]) - st;
        if (s < 0) begin
          m_unf[d][c] = 1'b1;
          s = sat ? 0 : s + (MAXV + 1);
        end
        m_cnt[d][c] = s;
      end
    end
    m_err[d] = (ec ? 4'h0 : m_err[d]) | m_ovf[d] | m_unf[d];
  endtask

  // Called at a falling edge: drive one cycle of inputs, predict, and return at the next falling edge.
  task automatic applyStimulus(input bit ce, input logic [3:0] ld, input logic [3:0] inc,
                               input logic [3:0] dec, input logic [15:0] stp,
                               input logic [63:0] lv, input bit ec);
    sat_bus.clken = ce;  sat_bus.load = ld;  sat_bus.incr = inc;  sat_bus.decr = dec;
    sat_bus.step = stp;  sat_bus.load_value = lv;  sat_bus.err_clr = ec;
    wrap_bus.clken = ce; wrap_bus.load = ld; wrap_bus.incr = inc; wrap_bus.decr = dec;
    wrap_bus.step = stp; wrap_bus.load_value = lv; wrap_bus.err_clr = ec;
    modelStep(0, 1'b1, ce, ld, inc, dec, stp, lv, ec);
    modelStep(1, 1'b0, ce, ld, inc, dec, stp, lv, ec);
    sat_q.push_back(modelSnap(0));
    wrap_q.push_back(modelSnap(1));
    @(negedge clk);
  endtask

  task automatic checkAsyncReset(input string tag);
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    compareSnap({tag, ".sat"},  readSat(),  modelSnap(0));
    compareSnap({tag, ".wrap"}, readWrap(), modelSnap(1));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  always @(posedge clk) begin
    #1;
    if (sat_q.size() > 0)  compareSnap("sat",  readSat(),  sat_q.pop_front());
    if (wrap_q.size() > 0) compareSnap("wrap", readWrap(), wrap_q.pop_front());
  end

  function automatic logic [15:0] randValue();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'h0001;
      2: return 16'hFFFE;
      3: return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic randomCycles(input int n);
    logic [3:0]  ld, inc, dec;
    logic [63:0] lv;
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < CH; c++) begin
        ld[c]  = ($urandom_range(0, 7) == 0);
        inc[c] = $urandom_range(0, 1) == 1;
        dec[c] = $urandom_range(0, 1) == 1;
        lv[c*W +: W] = randValue();
      end
      applyStimulus($urandom_range(0, 9) != 0, ld, inc, dec, 16'($urandom), lv,
                    $urandom_range(0, 9) == 0);
    end
  endtask

  initial begin
    applyIdle();
    modelReset();
    #2;
    rst_n = 1'b0;
    #1;
    compareSnap("reset.sat",  readSat(),  modelSnap(0));
    compareSnap("reset.wrap", readWrap(), modelSnap(1));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // ch0: load 10, +5 x3, -7
    applyStimulus(1, 4'b0001, 4'b0000, 4'b0000, 16'h0000, 64'd10, 0);
    repeat (3) applyStimulus(1, 4'b0000, 4'b0001, 4'b0000, 16'h0005, 64'd0, 0);
    applyStimulus(1, 4'b0000, 4'b0000, 4'b0001, 16'h0007, 64'd0, 0);

    // ch1: load 0xFFFD then +4 overflows; load 2 then -3 underflows
    applyStimulus(1, 4'b0010, 4'b0000, 4'b0000, 16'h0000, 64'hFFFD_0000, 0);
    applyStimulus(1, 4'b0000, 4'b0010, 4'b0000, 16'h0040, 64'd0, 0);
    applyStimulus(1, 4'b0000, 4'b0000, 4'b0000, 16'h0000, 64'd0, 0);
    applyStimulus(1, 4'b0010, 4'b0000, 4'b0000, 16'h0000, 64'h0002_0000, 0);
    applyStimulus(1, 4'b0000, 4'b0000, 4'b0010, 16'h0030, 64'd0, 0);

    // ch2: load 0xFFFE, +3, then -2
    applyStimulus(1, 4'b0100, 4'b0000, 4'b0000, 16'h0000, 64'hFFFE_0000_0000, 0);
    applyStimulus(1, 4'b0000, 4'b0100, 4'b0000, 16'h0300, 64'd0, 0);
    applyStimulus(1, 4'b0000, 4'b0000, 4'b0100, 16'h0200, 64'd0, 0);

    // Priority: load beats incr; incr+decr holds; step 0 holds
    applyStimulus(1, 4'b1000, 4'b1000, 4'b0000, 16'hF000, 64'h1234_0000_0000_0000, 0);
    applyStimulus(1, 4'b0000, 4'b0001, 4'b0001, 16'h000F, 64'd0, 0);
    applyStimulus(1, 4'b0000, 4'b1111, 4'b0000, 16'h0000, 64'd0, 0);

    // err_clr racing a new overflow keeps the bit; err_clr alone clears
    applyStimulus(1, 4'b0010, 4'b0000, 4'b0000, 16'h0000, 64'hFFFF_0000, 0);
    applyStimulus(1, 4'b0000, 4'b0010, 4'b0000, 16'h0010, 64'd0, 1);
    applyStimulus(1, 4'b0000, 4'b0000, 4'b0000, 16'h0000, 64'd0, 1);

    // Overflow pulse, then clken low with incr requested: everything frozen
    applyStimulus(1, 4'b0000, 4'b0010, 4'b0000, 16'h0010, 64'd0, 0);
    repeat (5) applyStimulus(0, 4'b0000, 4'b1111, 4'b0000, 16'h1111, 64'd0, 0);
    applyStimulus(1, 4'b0000, 4'b0000, 4'b0000, 16'h0000, 64'd0, 0);

    randomCycles(400);
    checkAsyncReset("midrun_reset");
    randomCycles(100);

    @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  task automatic applyIdle();
    sat_bus.clken = 1'b1;  sat_bus.load = '0;  sat_bus.incr = '0;  sat_bus.decr = '0;
    sat_bus.step = '0;     sat_bus.load_value = '0;  sat_bus.err_clr = 1'b0;
    wrap_bus.clken = 1'b1; wrap_bus.load = '0; wrap_bus.incr = '0; wrap_bus.decr = '0;
    wrap_bus.step = '0;    wrap_bus.load_value = '0; wrap_bus.err_clr = 1'b0;
  endtask

endmodule
